// File: rtl/ime_joint_framer_mc_pkg.sv
// Shared types for the multi-channel joint framer: sample payload, channel state
// and the mode legality helper.
package ime_pkg;

  localparam int IME_MODE_W = 5;
  localparam int IME_W_P    = 16;
  // Payload channel field is sized for up to 256 channels; the top truncates to CH_W.
  localparam int IME_CH_W   = 8;

  typedef enum logic {
    FRAME = 1'b0,
    SKIP  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [IME_W_P-1:0]  joint;
    logic [IME_W_P-1:0]  marg_x;
    logic [IME_W_P-1:0]  marg_y;
    logic [IME_CH_W-1:0] ch;
    logic                first;
    logic                last;
    logic                poison;
  } ime_sample_t;

  function automatic logic mode_exact1(input logic [IME_MODE_W-1:0] m);
    return (m != '0) && ((m & (m - IME_MODE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ime_joint_framer_mc_if.sv
// Input and output sample streams of the joint framer, bundled for port hookup.
// Handshake: a beat transfers on a cycle where valid && ready are both high; valid
// never waits on ready, and payload is held stable while valid is high and ready low.
interface ime_joint_framer_mc_if #(
  parameter int W_P  = 16,
  parameter int CH_W = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [W_P-1:0]  in_p_joint;
  logic [W_P-1:0]  in_p_marg_x;
  logic [W_P-1:0]  in_p_marg_y;
  logic            in_last;
  logic            in_poison;

  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [W_P-1:0]  out_p_joint;
  logic [W_P-1:0]  out_p_marg_x;
  logic [W_P-1:0]  out_p_marg_y;
  logic            out_first;
  logic            out_last;
  logic            out_poison;

  modport master (
    output in_valid, in_ch, in_p_joint, in_p_marg_x, in_p_marg_y, in_last, in_poison,
    output out_ready,
    input  in_ready,
    input  out_valid, out_ch, out_p_joint, out_p_marg_x, out_p_marg_y,
    input  out_first, out_last, out_poison
  );

  modport slave (
    input  in_valid, in_ch, in_p_joint, in_p_marg_x, in_p_marg_y, in_last, in_poison,
    input  out_ready,
    output in_ready,
    output out_valid, out_ch, out_p_joint, out_p_marg_x, out_p_marg_y,
    output out_first, out_last, out_poison
  );
endinterface

// File: rtl/ime_joint_framer_mc_sync_fifo.sv
// Synchronous FIFO with full/empty flags; the head word reads as zero when empty.
module ime_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/ime_joint_framer_mc.sv
// Multi-channel joint framer: per-channel frame/stride tracking with sticky poison,
// feeding an in-order output FIFO toward the log2 stage.
module ime_joint_framer_mc
  import ime_pkg::*;
#(
  parameter int W_P        = IME_W_P,
  parameter int N_CH       = 4,
  parameter int CH_W       = $clog2(N_CH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ime_joint_framer_mc_if.slave  bus,
  input  logic [15:0]           frame_len,
  input  logic [15:0]           frame_stride,
  input  logic [IME_MODE_W-1:0] mode_onehot,
  output logic [15:0]           frame_count,
  output logic                  mode_err,
  output logic [N_CH-1:0]       dbg_skip
);
  localparam int N_SLOT = 1 << CH_W;

  ch_state_e   st     [N_SLOT];
  logic [15:0] idx    [N_SLOT];
  logic [15:0] skip   [N_SLOT];
  logic        sticky [N_SLOT];

  ch_state_e   cur_st;
  logic [15:0] cur_idx, cur_skip, len_eff, gap;
  logic        cur_sticky, mode_bad, done, accept, push, pop, full, empty;
  ime_sample_t wr_s, head;

  always_comb begin
    len_eff    = (frame_len == 16'd0) ? 16'd1 : frame_len;
    gap        = (frame_stride > len_eff) ? (frame_stride - len_eff) : 16'd0;
    mode_bad   = (mode_onehot != '0) && !mode_exact1(mode_onehot);
    cur_st     = st[bus.in_ch];
    cur_idx    = idx[bus.in_ch];
    cur_skip   = skip[bus.in_ch];
    cur_sticky = sticky[bus.in_ch];
    // 17-bit compare so idx+1 cannot wrap past a 0xFFFF frame length.
    done       = bus.in_last || (({1'b0, cur_idx} + 17'd1) >= {1'b0, len_eff});
    accept     = bus.in_valid && !full;
    push       = accept && (cur_st == FRAME);
    pop        = bus.out_ready && !empty;

    wr_s        = '0;
    wr_s.joint  = IME_W_P'(bus.in_p_joint);
    wr_s.marg_x = IME_W_P'(bus.in_p_marg_x);
    wr_s.marg_y = IME_W_P'(bus.in_p_marg_y);
    wr_s.ch     = IME_CH_W'(bus.in_ch);
    wr_s.first  = (cur_idx == 16'd0);
    wr_s.last   = done;
    wr_s.poison = bus.in_poison || mode_bad || cur_sticky;
  end

  always_comb begin
    dbg_skip = '0;
    for (int i = 0; i < N_CH; i++) dbg_skip[i] = (st[i] == SKIP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOT; i++) begin
        st[i]     <= FRAME;
        idx[i]    <= '0;
        skip[i]   <= '0;
        sticky[i] <= 1'b0;
      end
      frame_count <= '0;
      mode_err    <= 1'b0;
    end else if (accept) begin
      if (mode_bad) mode_err <= 1'b1;
      if (cur_st == FRAME) begin
        if (done) begin
          idx[bus.in_ch]    <= '0;
          sticky[bus.in_ch] <= 1'b0;
          frame_count       <= frame_count + 16'd1;
          if (gap != 16'd0) begin
            skip[bus.in_ch] <= gap;
            st[bus.in_ch]   <= SKIP;
          end
        end else begin
          idx[bus.in_ch]    <= cur_idx + 16'd1;
          sticky[bus.in_ch] <= cur_sticky || bus.in_poison || mode_bad;
        end
      end else begin
        // Dropped sample: its poison is ignored; in_last cuts the gap short.
        if (bus.in_last || (cur_skip <= 16'd1)) begin
          st[bus.in_ch]   <= FRAME;
          skip[bus.in_ch] <= '0;
          idx[bus.in_ch]  <= '0;
        end else begin
          skip[bus.in_ch] <= cur_skip - 16'd1;
        end
      end
    end
  end

  ime_sync_fifo #(
    .WIDTH ($bits(ime_sample_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_s),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready     = !full;
  assign bus.out_valid    = !empty;
  assign bus.out_ch       = CH_W'(head.ch);
  assign bus.out_p_joint  = W_P'(head.joint);
  assign bus.out_p_marg_x = W_P'(head.marg_x);
  assign bus.out_p_marg_y = W_P'(head.marg_y);
  assign bus.out_first    = head.first;
  assign bus.out_last     = head.last;
  assign bus.out_poison   = head.poison;
endmodule

// File: tb/tb_ime_joint_framer_mc.sv
// Bench for ime_joint_framer_mc: vector table, hand sequences for latency/full/reset,
// and random traffic checked against a frame-position reference model.
module tb_ime_joint_framer_mc;
  localparam int W_P = 16, N_CH = 4, CH_W = 2, FIFO_DEPTH = 4;
  localparam int EW  = CH_W + 3 * W_P + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ime_joint_framer_mc_if #(.W_P(W_P), .CH_W(CH_W)) bus();
  logic [15:0]     frame_len, frame_stride, frame_count;
  logic [4:0]      mode_onehot;
  logic            mode_err;
  logic [N_CH-1:0] dbg_skip;

  ime_joint_framer_mc #(.W_P(W_P), .N_CH(N_CH), .CH_W(CH_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .frame_len    (frame_len),
    .frame_stride (frame_stride),
    .mode_onehot  (mode_onehot),
    .frame_count  (frame_count),
    .mode_err     (mode_err),
    .dbg_skip     (dbg_skip)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // out_ready only changes just after a rising edge
  always @(posedge clk) begin
    #1;
    bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got = {bus.out_ch, bus.out_p_joint, bus.out_p_marg_x, bus.out_p_marg_y,
             bus.out_first, bus.out_last, bus.out_poison};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %0h expected nothing", got);
      end else begin
        chk("out_sample", 64'(got), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- reference model: position within frame period ----------------
  int unsigned m_pos[N_CH];
  logic        m_stk[N_CH];
  logic [15:0] m_fc;
  logic        m_merr;

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_pos[c] = 0;
      m_stk[c] = 1'b0;
    end
    m_fc   = '0;
    m_merr = 1'b0;
  endfunction

  function automatic void model_step(input int ch, input logic [W_P-1:0] j, mx, my,
                                     input logic last, poison, input logic [4:0] mode);
    int   len_e, period;
    logic illegal, dn;
    len_e   = (frame_len == 16'd0) ? 1 : int'(frame_len);
    period  = (int'(frame_stride) > len_e) ? int'(frame_stride) : len_e;
    illegal = ($countones(mode) > 1);
    if (illegal) m_merr = 1'b1;
    if (m_pos[ch] < len_e) begin
      dn = last || (m_pos[ch] + 1 >= len_e);
      exp_q.push_back({CH_W'(ch), j, mx, my, (m_pos[ch] == 0), dn, poison | illegal | m_stk[ch]});
      m_stk[ch] = m_stk[ch] | poison | illegal;
      if (dn) begin
        m_fc      = m_fc + 16'd1;
        m_stk[ch] = 1'b0;
        m_pos[ch] = (period > len_e) ? len_e : 0;
      end else begin
        m_pos[ch] = m_pos[ch] + 1;
      end
    end else begin
      m_pos[ch] = (last || (m_pos[ch] + 1 >= period)) ? 0 : m_pos[ch] + 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive(input int ch, input logic [W_P-1:0] j, mx, my,
                       input logic last, poison, input logic [4:0] mode, output logic ok);
    @(negedge clk);
    bus.in_ch = CH_W'(ch);
    bus.in_p_joint = j;
    bus.in_p_marg_x = mx;
    bus.in_p_marg_y = my;
    bus.in_last = last;
    bus.in_poison = poison;
    mode_onehot = mode;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (bus.in_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drive_timeout: in_ready=%0b expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drive_model(input int ch, input logic last, poison, input logic [4:0] mode);
    logic [W_P-1:0] j, mx, my;
    logic ok;
    j  = W_P'($urandom);
    mx = W_P'($urandom);
    my = W_P'($urandom);
    drive(ch, j, mx, my, last, poison, mode, ok);
    if (ok) model_step(ch, j, mx, my, last, poison, mode);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    #1 chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    int          ch;
    logic [15:0] len, stride;
    logic [4:0]  mode;
    logic        last, poison;
    logic [15:0] val;
    logic        push, f, l, p;
    logic [15:0] fc;
    logic        merr;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rst, input int ch, input logic [15:0] len, stride,
                              input logic [4:0] mode, input logic last, poison,
                              input logic [15:0] val, input logic push, f, l, p,
                              input logic [15:0] fc, input logic merr);
    vec_t v;
    v = '{rst, ch, len, stride, mode, last, poison, val, push, f, l, p, fc, merr};
    tbl.push_back(v);
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    logic ok;
    logic [15:0] v16;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_last = 1'b0; bus.in_poison = 1'b0;
    bus.in_p_joint = '0; bus.in_p_marg_x = '0; bus.in_p_marg_y = '0;
    frame_len = 16'd4; frame_stride = 16'd0; mode_onehot = '0;
    model_reset();

    // stride 5 / len 2 on ch1: values 2-4 and 7-9 are dropped
    add(1, 1, 2, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 2, 5, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0);
    for (int i = 2; i < 5; i++) add(0, 1, 2, 5, 0, 0, 0, 16'(i), 0, 0, 0, 0, 1, 0);
    add(0, 1, 2, 5, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0);
    add(0, 1, 2, 5, 0, 0, 0, 6, 1, 0, 1, 0, 2, 0);
    for (int i = 7; i < 10; i++) add(0, 1, 2, 5, 0, 0, 0, 16'(i), 0, 0, 0, 0, 2, 0);
    // poison on 2nd sample sticks to end of frame only
    add(1, 0, 4, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0);
    add(0, 0, 4, 0, 0, 0, 1, 11, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4, 0, 0, 0, 0, 12, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4, 0, 0, 0, 0, 13, 1, 0, 1, 1, 1, 0);
    add(0, 0, 4, 0, 0, 0, 0, 14, 1, 1, 0, 0, 1, 0);
    add(0, 0, 4, 0, 0, 0, 0, 15, 1, 0, 0, 0, 1, 0);
    add(0, 0, 4, 0, 0, 0, 0, 16, 1, 0, 0, 0, 1, 0);
    add(0, 0, 4, 0, 0, 0, 0, 17, 1, 0, 1, 0, 2, 0);
    // illegal mode poisons the rest of the frame and latches mode_err
    add(1, 2, 4, 0, 5'b00001, 0, 0, 20, 1, 1, 0, 0, 0, 0);
    add(0, 2, 4, 0, 5'b00110, 0, 0, 21, 1, 0, 0, 1, 0, 1);
    add(0, 2, 4, 0, 5'b00000, 0, 0, 22, 1, 0, 0, 1, 0, 1);
    add(0, 2, 4, 0, 5'b00000, 0, 0, 23, 1, 0, 1, 1, 1, 1);
    add(0, 2, 4, 0, 5'b10000, 0, 0, 24, 1, 1, 0, 0, 1, 1);
    // len 0 as 1, in_last, mid-frame shrink, in_last in gap, poison in gap
    add(1, 3, 0, 0, 0, 0, 0, 30, 1, 1, 1, 0, 1, 0);
    add(0, 3, 0, 0, 0, 0, 0, 31, 1, 1, 1, 0, 2, 0);
    add(0, 3, 4, 0, 0, 0, 0, 32, 1, 1, 0, 0, 2, 0);
    add(0, 3, 4, 0, 0, 1, 0, 33, 1, 0, 1, 0, 3, 0);
    add(0, 3, 4, 0, 0, 0, 0, 34, 1, 1, 0, 0, 3, 0);
    add(0, 3, 4, 0, 0, 0, 0, 35, 1, 0, 0, 0, 3, 0);
    add(0, 3, 2, 0, 0, 0, 0, 36, 1, 0, 1, 0, 4, 0);
    add(0, 3, 2, 0, 0, 0, 0, 37, 1, 1, 0, 0, 4, 0);
    add(0, 3, 1, 3, 0, 0, 0, 38, 1, 0, 1, 0, 5, 0);
    add(0, 3, 1, 3, 0, 0, 0, 39, 0, 0, 0, 0, 5, 0);
    add(0, 3, 1, 3, 0, 1, 0, 40, 0, 0, 0, 0, 5, 0);
    add(0, 3, 1, 3, 0, 0, 0, 41, 1, 1, 1, 0, 6, 0);
    add(0, 3, 1, 3, 0, 0, 1, 42, 0, 0, 0, 0, 6, 0);
    add(0, 3, 1, 3, 0, 0, 0, 43, 0, 0, 0, 0, 6, 0);
    add(0, 3, 1, 3, 0, 0, 0, 44, 1, 1, 1, 0, 7, 0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_payload", 64'({bus.out_ch, bus.out_p_joint, bus.out_first, bus.out_last, bus.out_poison}), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_mode_err", 64'(mode_err), 64'd0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // len 4, 8 samples: each output one cycle after accept
    do_reset();
    frame_len = 16'd4; frame_stride = 16'd0;
    for (int i = 0; i < 8; i++) begin
      v16 = 16'(100 + i);
      exp_q.push_back({CH_W'(0), v16, v16 ^ 16'h5a5a, v16 + 16'h0100, (i % 4 == 0), (i % 4 == 3), 1'b0});
      drive(0, v16, v16 ^ 16'h5a5a, v16 + 16'h0100, 1'b0, 1'b0, 5'd0, ok);
      @(negedge clk);
      chk("t1_latency", 64'(bus.out_valid), 64'd1);
    end
    wait_drain("t1_drain");
    chk("t1_frame_count", 64'(frame_count), 64'd2);

    // table vectors
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        wait_drain("tbl_drain");
        do_reset();
      end
      frame_len = tbl[i].len;
      frame_stride = tbl[i].stride;
      v16 = tbl[i].val;
      drive(tbl[i].ch, v16, v16 ^ 16'h5a5a, v16 + 16'h0100, tbl[i].last, tbl[i].poison, tbl[i].mode, ok);
      if (ok && tbl[i].push)
        exp_q.push_back({CH_W'(tbl[i].ch), v16, v16 ^ 16'h5a5a, v16 + 16'h0100, tbl[i].f, tbl[i].l, tbl[i].p});
      chk("tbl_frame_count", 64'(frame_count), 64'(tbl[i].fc));
      chk("tbl_mode_err", 64'(mode_err), 64'(tbl[i].merr));
    end
    chk("tbl_dbg_skip", 64'(dbg_skip), 64'(4'b1000));
    wait_drain("tbl_drain");

    // interleaved ch0/ch1, len 3
    do_reset();
    frame_len = 16'd3; frame_stride = 16'd0;
    for (int i = 0; i < 12; i++) drive_model(i % 2, 1'b0, 1'b0, 5'd0);
    wait_drain("t3_drain");
    chk("t3_frame_count", 64'(frame_count), 64'd4);

    // fill with out_ready low, then reset mid-stream
    do_reset();
    rdy_mode = 1;
    @(posedge clk);
    #2 frame_len = 16'd1;
    for (int i = 0; i < 4; i++) drive_model(0, 1'b0, 1'b0, 5'd0);
    chk("t6_in_ready_full", 64'(bus.in_ready), 64'd0);
    chk("t6_out_valid_full", 64'(bus.out_valid), 64'd1);
    chk("t6_frame_count", 64'(frame_count), 64'd4);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_frame_count", 64'(frame_count), 64'd0);
    chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    model_reset();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    frame_len = 16'd4;
    drive_model(2, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("t6_first_after_rst", 64'(bus.out_first), 64'd1);
    wait_drain("t6_drain");

    // random traffic against the model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      frame_len = 16'($urandom_range(0, 5));
      frame_stride = 16'($urandom_range(0, 8));
      rdy_mode = 2;
      for (int i = 0; i < 250; i++) begin
        int sel;
        logic [4:0] md;
        sel = $urandom_range(0, 39);
        md = (sel == 0) ? 5'b01100 : (sel < 20) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
        drive_model($urandom_range(0, N_CH - 1), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 7) == 0), md);
      end
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      wait_drain("rnd_drain");
      chk("rnd_frame_count", 64'(frame_count), 64'(m_fc));
      chk("rnd_mode_err", 64'(mode_err), 64'(m_merr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
